// File: rtl/acc_sequencer_pkg.sv
// Shared definitions for the adder-accumulator sequencer: FSM state
// encodings, button indices, display mux selects and a width helper.
package acc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_ADD_GO   = 3'd2,
        ST_ADD_WAIT = 3'd3,
        ST_ADD_WB   = 3'd4
    } seq_state_t;

    // Button lanes inside the sequencer.
    localparam int BTN_LOAD = 0;
    localparam int BTN_ADD  = 1;
    localparam int NUM_BTNS = 2;

    // Display mux selects used by the board top to pick the 7-segment source.
    localparam logic [1:0] DISP_SEL_SW    = 2'd0;
    localparam logic [1:0] DISP_SEL_R1    = 2'd1;
    localparam logic [1:0] DISP_SEL_ACC   = 2'd2;
    localparam logic [1:0] DISP_SEL_COUNT = 2'd3;

    // Bits needed to hold the values 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/acc_sequencer_btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a
// one-cycle press pulse on the rising edge of the debounced level.
module btn_debounce
    import acc_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          db_reg;
    logic          db_prev_reg;
    logic [CW-1:0] cnt_reg;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
        end
    end

    // Count how long the synchronised level has differed from the accepted
    // level; any return to the accepted level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            db_reg      <= 1'b0;
            db_prev_reg <= 1'b0;
        end else begin
            db_prev_reg <= db_reg;
            if (sync2_reg == db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                db_reg  <= sync2_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign press = db_reg & ~db_prev_reg;

endmodule

// File: rtl/acc_sequencer.sv
// Button-driven sequencer for the 8-bit operand / 16-bit accumulator
// datapath: debounced commands, depth-1 pending flags, strobe FSM and
// completed-add counter with sticky overflow.
module acc_sequencer
    import acc_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ADDER_LATENCY   = 2,
    parameter int CNT_W           = 16
) (
    input  logic             MCLK,
    input  logic             reset,
    input  logic             btn_load,
    input  logic             btn_add,
    input  logic             acc_carry,
    output logic             r1_we,
    output logic             r2_we,
    output logic             op_valid,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] add_count
);

    localparam int            WW        = cnt_width(ADDER_LATENCY);
    localparam logic [WW-1:0] WAIT_INIT = WW'(ADDER_LATENCY - 1);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] press;

    seq_state_t    state_reg, state_next;
    logic [WW-1:0] wait_reg, wait_next;
    logic          load_pend_reg;
    logic          add_pend_reg;
    logic          load_take;
    logic          add_take;

    assign btn_raw[BTN_LOAD] = btn_load;
    assign btn_raw[BTN_ADD]  = btn_add;

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (MCLK),
            .rst  (reset),
            .btn  (btn_raw[gi]),
            .press(press[gi])
        );
    end

    // Pending commands: one slot per type; acceptance by the FSM wins over a
    // press landing in the same cycle, so a press while set is dropped.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            load_pend_reg <= 1'b0;
            add_pend_reg  <= 1'b0;
        end else begin
            if (load_take)
                load_pend_reg <= 1'b0;
            else if (press[BTN_LOAD])
                load_pend_reg <= 1'b1;
            if (add_take)
                add_pend_reg <= 1'b0;
            else if (press[BTN_ADD])
                add_pend_reg <= 1'b1;
        end
    end

    // Next-state logic; LOAD has priority over ADD when both are pending.
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        load_take  = 1'b0;
        add_take   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (load_pend_reg) begin
                    state_next = ST_LOAD;
                    load_take  = 1'b1;
                end else if (add_pend_reg) begin
                    state_next = ST_ADD_GO;
                    add_take   = 1'b1;
                end
            end
            ST_LOAD:   state_next = ST_IDLE;
            ST_ADD_GO: begin
                wait_next  = WAIT_INIT;
                state_next = (ADDER_LATENCY == 1) ? ST_ADD_WB : ST_ADD_WAIT;
            end
            // Leave on the cycle the count would reach zero so that r2_we
            // coincides with the adder's sum-valid cycle.
            ST_ADD_WAIT: begin
                if (wait_reg <= WW'(1))
                    state_next = ST_ADD_WB;
                else
                    wait_next = wait_reg - WW'(1);
            end
            ST_ADD_WB: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register; strobes are registered and decoded from the next state
    // so each one is high exactly while the FSM sits in its state.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            wait_reg  <= '0;
            r1_we     <= 1'b0;
            op_valid  <= 1'b0;
            r2_we     <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            r1_we     <= (state_next == ST_LOAD);
            op_valid  <= (state_next == ST_ADD_GO);
            r2_we     <= (state_next == ST_ADD_WB);
        end
    end

    // Completed-add bookkeeping; acc_carry is sampled in the write-back cycle.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            add_count <= '0;
            overflow  <= 1'b0;
        end else if (state_reg == ST_ADD_WB) begin
            add_count <= add_count + CNT_W'(1);
            overflow  <= overflow | acc_carry;
        end
    end

    assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer. Three instances share clock and
// reset and differ only in adder latency (2, 8, 32). A behavioural model
// tracks the expected add count, overflow and load count per instance.
module tb_acc_sequencer;

    localparam int NI = 3;
    localparam int LATS [NI] = '{2, 8, 32};

    logic        clk;
    logic        reset;
    logic        bl    [NI];
    logic        ba    [NI];
    logic        carry [NI];
    logic        r1    [NI];
    logic        r2    [NI];
    logic        opv   [NI];
    logic        bsy   [NI];
    logic        ovf   [NI];
    logic [15:0] cnt   [NI];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int n_r1 [NI] = '{default: 0};
    int n_op [NI] = '{default: 0};
    int n_r2 [NI] = '{default: 0};
    int t_r1 [NI] = '{default: 0};
    int t_op [NI] = '{default: 0};
    int t_r2 [NI] = '{default: 0};

    // model state
    int exp_cnt [NI] = '{default: 0};
    int exp_ovf [NI] = '{default: 0};
    int exp_r1  [NI] = '{default: 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        acc_sequencer #(
            .DEBOUNCE_CYCLES(4),
            .ADDER_LATENCY  (LATS[gi]),
            .CNT_W          (16)
        ) u_dut (
            .MCLK     (clk),
            .reset    (reset),
            .btn_load (bl[gi]),
            .btn_add  (ba[gi]),
            .acc_carry(carry[gi]),
            .r1_we    (r1[gi]),
            .r2_we    (r2[gi]),
            .op_valid (opv[gi]),
            .busy     (bsy[gi]),
            .overflow (ovf[gi]),
            .add_count(cnt[gi])
        );

        // Strobe monitor, sampled on the falling edge.
        always @(negedge clk) begin
            if (!reset) begin
                if (r1[gi]) begin
                    n_r1[gi]++;
                    t_r1[gi] = cyc;
                end
                if (opv[gi]) begin
                    n_op[gi]++;
                    t_op[gi] = cyc;
                end
                if (r2[gi]) begin
                    n_r2[gi]++;
                    t_r2[gi] = cyc;
                    check_value("r2_after_op_latency", cyc - t_op[gi], LATS[gi]);
                    $display("[cyc %0d] inst%0d add write-back, count before=%0d carry=%0d",
                             cyc, gi, cnt[gi], carry[gi]);
                end
                if (r1[gi] || r2[gi] || opv[gi])
                    check_value("strobe_exclusive", int'(r1[gi]) + int'(r2[gi]) + int'(opv[gi]), 1);
            end
        end
    end

    task automatic check_value(input string tag, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, expv, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input int mask, input logic v);
        if (mask[0]) bl[i] = v;
        if (mask[1]) ba[i] = v;
    endtask

    // mask bit0 = LOAD, bit1 = ADD; optional glitches shorter than the
    // debounce window precede the real press.
    task automatic press(input int i, input int mask, input int hold, input int rel,
                         input int glitches, input int gw);
        for (int k = 0; k < glitches; k++) begin
            drive(i, mask, (k % 2 == 0) ? 1'b1 : 1'b0);
            step((gw > 0) ? gw : int'($urandom_range(1, 3)));
        end
        drive(i, mask, 1'b1);
        step(hold);
        drive(i, mask, 1'b0);
        step(rel);
    endtask

    task automatic wait_idle(input int i);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 400) begin
            step(1);
            n++;
            quiet = bsy[i] ? 0 : quiet + 1;
        end
        if (quiet < 3) check_value("wait_idle_timeout", n, -1);
    endtask

    task automatic check_model(input int i, input string tag);
        check_value({tag, "_count"}, int'(cnt[i]), exp_cnt[i] % 65536);
        check_value({tag, "_overflow"}, int'(ovf[i]), exp_ovf[i]);
    endtask

    task automatic reset_all();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            exp_cnt[i] = 0;
            exp_ovf[i] = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_r1, b_op, b_r2, t0, lat, kind, c;
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            bl[i] = 1'b0;
            ba[i] = 1'b0;
            carry[i] = 1'b0;
        end
        step(1);

        // 1: reset, then idle
        reset = 1'b0;
        step(10);
        for (int i = 0; i < NI; i++) begin
            check_value("reset_r1_we", int'(r1[i]), 0);
            check_value("reset_r2_we", int'(r2[i]), 0);
            check_value("reset_op_valid", int'(opv[i]), 0);
            check_value("reset_busy", int'(bsy[i]), 0);
            check_value("reset_overflow", int'(ovf[i]), 0);
            check_value("reset_add_count", int'(cnt[i]), 0);
            check_value("reset_no_strobes", n_r1[i] + n_op[i] + n_r2[i], 0);
        end

        // 2: single load held long
        b_r1 = n_r1[0];
        t0 = cyc;
        drive(0, 1, 1'b1);
        step(10);
        check_value("load_one_pulse", n_r1[0] - b_r1, 1);
        lat = t_r1[0] - t0;
        check_value("load_latency_5_to_12", int'(lat >= 5 && lat <= 12), 1);
        step(50);
        check_value("load_hold_no_repeat", n_r1[0] - b_r1, 1);
        drive(0, 1, 1'b0);
        step(20);
        check_value("load_release_no_pulse", n_r1[0] - b_r1, 1);
        exp_r1[0] = 1;

        // 3: bouncing add, toggling every 2 cycles for 20 cycles
        b_op = n_op[0];
        b_r2 = n_r2[0];
        press(0, 2, 12, 10, 10, 2);
        wait_idle(0);
        exp_cnt[0]++;
        check_value("bounce_one_op_valid", n_op[0] - b_op, 1);
        check_value("bounce_one_r2_we", n_r2[0] - b_r2, 1);
        check_model(0, "bounce");

        // 4: simultaneous load and add
        b_r1 = n_r1[0];
        b_op = n_op[0];
        b_r2 = n_r2[0];
        press(0, 3, 10, 10, 0, 0);
        wait_idle(0);
        exp_cnt[0]++;
        check_value("simul_r1_count", n_r1[0] - b_r1, 1);
        check_value("simul_op_count", n_op[0] - b_op, 1);
        check_value("simul_r2_count", n_r2[0] - b_r2, 1);
        check_value("simul_load_before_op", int'(t_r1[0] < t_op[0]), 1);
        check_value("simul_op_before_r2", int'(t_op[0] < t_r2[0]), 1);
        check_model(0, "simul");
        exp_r1[0]++;

        // 5a: latency 8, second add pressed while the first is in flight
        b_r2 = n_r2[1];
        press(1, 2, 4, 4, 0, 0);
        press(1, 2, 6, 10, 0, 0);
        wait_idle(1);
        exp_cnt[1] += 2;
        check_value("capture_two_r2", n_r2[1] - b_r2, 2);
        check_model(1, "capture");

        // 5b: latency 32, three presses inside one busy window; third dropped
        b_r2 = n_r2[2];
        b_op = n_op[2];
        for (int k = 0; k < 3; k++) press(2, 2, 6, 6, 0, 0);
        check_value("drop_busy_during_presses", int'(bsy[2]), 1);
        wait_idle(2);
        exp_cnt[2] += 2;
        check_value("drop_two_op_valid", n_op[2] - b_op, 2);
        check_value("drop_two_r2", n_r2[2] - b_r2, 2);
        check_model(2, "drop");

        // randomized command mix on the latency-2 instance
        for (int k = 0; k < 24; k++) begin
            kind = int'($urandom_range(1, 3));
            c = int'($urandom_range(0, 1));
            carry[0] = c[0];
            press(0, kind, int'($urandom_range(5, 9)), int'($urandom_range(5, 9)),
                  int'($urandom_range(0, 5)), 0);
            wait_idle(0);
            if (kind[0]) exp_r1[0]++;
            if (kind[1]) begin
                exp_cnt[0]++;
                exp_ovf[0] = exp_ovf[0] | c;
            end
            check_value("rand_load_total", n_r1[0], exp_r1[0]);
            check_model(0, "rand");
        end
        carry[0] = 1'b0;

        // 6: 300 adds, carry only on add 256, then reset mid ADD_WAIT
        reset_all();
        step(2);
        for (int k = 1; k <= 300; k++) begin
            carry[1] = (k == 256);
            press(1, 2, int'($urandom_range(5, 9)), int'($urandom_range(5, 9)),
                  int'($urandom_range(0, 4)), 0);
            wait_idle(1);
            exp_cnt[1]++;
            if (k == 256) exp_ovf[1] = 1;
            check_model(1, "run300");
        end
        check_value("run300_final_count", int'(cnt[1]), 300);
        carry[1] = 1'b0;

        b_op = n_op[1];
        b_r2 = n_r2[1];
        drive(1, 2, 1'b1);
        step(5);
        drive(1, 2, 1'b0);
        t0 = 0;
        while (n_op[1] == b_op && t0 < 40) begin
            step(1);
            t0++;
        end
        check_value("abort_op_valid_seen", n_op[1] - b_op, 1);
        step(3);
        check_value("abort_busy_before_reset", int'(bsy[1]), 1);
        reset_all();
        step(20);
        check_value("abort_no_r2", n_r2[1] - b_r2, 0);
        check_value("abort_busy", int'(bsy[1]), 0);
        check_model(1, "abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
